// File: rtl/cd_pkg.sv
// Shared definitions for the cdbus RX fetch engine: FSM states, CSR map,
// RX_CTRL command values and frame-length helpers.
package cd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_FLAG,
    CHK_FLAG,
    WR_RST,
    RD_BYTE,
    CAP,
    HOLD,
    WR_DONE
  } state_t;

  localparam logic [4:0] A_INT_FLAG   = 5'h16;
  localparam logic [4:0] A_RX_DATA    = 5'h1a;
  localparam logic [4:0] A_RX_CTRL    = 5'h1c;

  localparam int         RX_PEND_BIT  = 1;
  localparam logic [7:0] CTRL_RST_PTR = 8'h01;
  localparam logic [7:0] CTRL_DONE    = 8'h02;

  localparam int         MAX_LEN      = 253;

  // Header (src, dst, len) plus payload; at most 256 bytes for a legal len.
  function automatic logic [8:0] frame_total(input logic [7:0] len);
    return 9'd3 + {1'b0, len};
  endfunction

  function automatic logic len_bad(input logic [7:0] len);
    return len > 8'(MAX_LEN);
  endfunction

endpackage

// File: rtl/cd_rx_fetch.sv
// CSR-bus initiator that drains pending cdbus RX frames and replays them
// downstream as a valid/ready byte stream, releasing the page afterwards.
module cd_rx_fetch #(
  parameter logic [4:0] A_INT_FLAG   = cd_pkg::A_INT_FLAG,
  parameter logic [4:0] A_RX_DATA    = cd_pkg::A_RX_DATA,
  parameter logic [4:0] A_RX_CTRL    = cd_pkg::A_RX_CTRL,
  parameter int         RX_PEND_BIT  = cd_pkg::RX_PEND_BIT,
  parameter logic [7:0] CTRL_RST_PTR = cd_pkg::CTRL_RST_PTR,
  parameter logic [7:0] CTRL_DONE    = cd_pkg::CTRL_DONE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       irq,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       len_err
);

  import cd_pkg::*;

  state_t     state;
  state_t     state_nx;
  logic [8:0] idx;
  logic [8:0] remaining;

  logic       cap_hdr;
  logic       cap_bad;
  logic [8:0] remaining_cap;
  logic       last_cap;

  // The len byte sets the frame size; an oversized len truncates the frame
  // to its header so the payload is never read.
  always_comb begin
    cap_hdr       = (idx == 9'd2);
    cap_bad       = cap_hdr && len_bad(csr_readdata);
    remaining_cap = remaining;
    if (cap_hdr) begin
      remaining_cap = cap_bad ? 9'd3 : frame_total(csr_readdata);
    end
    last_cap      = ((idx + 9'd1) == remaining_cap);
  end

  always_comb begin
    state_nx      = state;
    csr_address   = 5'd0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = 8'd0;
    case (state)
      IDLE: begin
        if (enable && irq) state_nx = RD_FLAG;
      end
      RD_FLAG: begin
        csr_read    = 1'b1;
        csr_address = A_INT_FLAG;
        state_nx    = CHK_FLAG;
      end
      CHK_FLAG: begin
        state_nx = csr_readdata[RX_PEND_BIT] ? WR_RST : IDLE;
      end
      WR_RST: begin
        csr_write     = 1'b1;
        csr_address   = A_RX_CTRL;
        csr_writedata = CTRL_RST_PTR;
        state_nx      = RD_BYTE;
      end
      RD_BYTE: begin
        csr_read    = 1'b1;
        csr_address = A_RX_DATA;
        state_nx    = CAP;
      end
      CAP: begin
        state_nx = HOLD;
      end
      HOLD: begin
        if (m_ready) state_nx = m_last ? WR_DONE : RD_BYTE;
      end
      WR_DONE: begin
        csr_write     = 1'b1;
        csr_address   = A_RX_CTRL;
        csr_writedata = CTRL_DONE;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == WR_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 9'd0;
      remaining <= 9'd0;
      m_data    <= 8'd0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      len_err <= 1'b0;
      case (state)
        WR_RST: begin
          idx       <= 9'd0;
          remaining <= 9'd0;
        end
        CAP: begin
          m_data    <= csr_readdata;
          m_valid   <= 1'b1;
          m_last    <= last_cap;
          remaining <= remaining_cap;
          len_err   <= cap_bad;
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            idx     <= idx + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cd_rx_fetch.md
# cd_rx_fetch

Host-side CSR-bus initiator that drains received frames out of a cdbus core and presents them as a byte stream. It drives the cdbus CSR read/write strobes and waits on `irq`. For each pending frame it checks INT_FLAG, rewinds the RX read pointer, reads the header and payload through RX_DATA, streams the bytes downstream with valid/ready, and then releases the RX page. It sits between the cdbus top and a streaming consumer (DMA, FIFO or soft core), replacing firmware polling.

## Interface
Parameters:
- `A_INT_FLAG`, 5'h16: CSR address of the interrupt flag register.
- `A_RX_DATA`, 5'h1a: CSR address of the RX data port (auto-incrementing read).
- `A_RX_CTRL`, 5'h1c: CSR address of the RX control register.
- `RX_PEND_BIT`, 1: bit index of rx_pending in INT_FLAG.
- `CTRL_RST_PTR`, 8'h01: RX_CTRL value that rewinds the read pointer.
- `CTRL_DONE`, 8'h02: RX_CTRL value that releases the RX page (clear pending).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: allows a new fetch to start.
- `irq` in 1: cdbus interrupt, level-sensitive.
- `csr_address` out 5: CSR address.
- `csr_read` out 1: one-cycle read strobe.
- `csr_readdata` in 8: read data, valid the cycle after `csr_read`.
- `csr_write` out 1: one-cycle write strobe.
- `csr_writedata` out 8: write data.
- `m_data` out 8: stream byte.
- `m_valid` out 1: stream valid.
- `m_last` out 1: marks the final byte of a frame.
- `m_ready` in 1: stream ready.
- `busy` out 1: high in any state except IDLE.
- `frame_done` out 1: one-cycle pulse when the page is released.
- `len_err` out 1: one-cycle pulse when the length byte exceeds 253.

## Operation
- Frame layout in the RX page: src, dst, len, then len payload bytes. Total bytes = 3 + len, at most 256.
- FSM states: IDLE, RD_FLAG, CHK_FLAG, WR_RST, RD_BYTE, CAP, HOLD, WR_DONE.
- IDLE → RD_FLAG when `enable & irq`.
- RD_FLAG: drive `csr_read=1`, `csr_address=A_INT_FLAG`.
- CHK_FLAG: sample `csr_readdata[RX_PEND_BIT]`. If 1, go to WR_RST; if 0, go to IDLE.
- WR_RST: drive `csr_write=1`, `csr_writedata=CTRL_RST_PTR`. Clear the byte index (9 bits) and the remaining count.
- RD_BYTE: drive `csr_read=1`, `csr_address=A_RX_DATA`.
- CAP: load `csr_readdata` into `m_data`, set `m_valid`. If index==2, latch len and set remaining = 3 + len.
- HOLD: hold `m_data`, `m_valid` and `m_last` stable until `m_ready`. On handshake, clear `m_valid` and increment the index. If more bytes remain, go to RD_BYTE; otherwise go to WR_DONE.
- `m_last=1` on the byte where index+1 == remaining.
- Length error: if len > 253 when captured at index 2, pulse `len_err` and mark that header byte `m_last`. The payload is not read.
- WR_DONE: drive `csr_write=1`, `csr_writedata=CTRL_DONE`. Pulse `frame_done` in the same cycle, then go to IDLE.
- `enable` falling mid-frame: the current frame completes; no new fetch starts.
- `irq` still high after WR_DONE: the next fetch starts via the INT_FLAG check, so a stale irq with pending=0 costs exactly two CSR cycles.
- Reset mid-frame: state returns to IDLE. The partial frame is abandoned, but the cdbus page stays pending; the next fetch rewinds the pointer via WR_RST and re-reads the whole frame.

## Timing
- Reset values: all outputs 0; `csr_address` = 0.
- `csr_read` and `csr_write` never assert in the same cycle, and each strobe is exactly one cycle.
- `irq` sampled high in IDLE → `csr_read` high on the next cycle.
- `m_valid` rises 2 cycles after its `csr_read` strobe.
- With `m_ready` held high, throughput is 1 byte per 3 cycles.
- The last handshake is followed by the WR_DONE write on the next cycle.
- A len=0 frame is 3 bytes; `m_last` is on the len byte.
- The index never wraps: the maximum is 255 with len=253.

## Structure
- Shared package `cd_pkg` holds: the state enum; the CSR address constants (`A_INT_FLAG`, `A_RX_DATA`, `A_RX_CTRL`); the RX_CTRL bit constants; and `MAX_LEN=253`.
- The block is a single module with no sub-modules. The CSR strobe generation is inline in the FSM output decode.

## Test plan
- irq=1, INT_FLAG reads 8'h02, frame {01,02,03,AA,BB,CC}, m_ready=1 → six bytes in order with `m_last` on CC. CSR sequence: rd 16, wr 1c=01, 6× rd 1a, wr 1c=02. One `frame_done` pulse. 3 cycles per byte.
- irq=1, INT_FLAG reads 8'h00 → exactly one CSR read, then IDLE, `busy` low 2 cycles after start, no stream output.
- len=0 frame {05,06,00} → 3 bytes with `m_last` on 00, then the release write.
- len=8'hFE → three header bytes with `m_last` on FE, a `len_err` pulse, no payload reads, then the release write.
- Backpressure: m_ready low for 5 cycles on byte 1 → `m_data`/`m_valid` stable and no `csr_read` issued during the stall; the stream resumes intact.
- Reset asserted after byte 2 of a 10-byte frame, with irq still high → all outputs 0. After reset, the refetch issues wr 1c=01 and the full 10-byte frame streams from the src byte.
